// File: rtl/pattern_bist_harness_if.sv
// Control, stimulus and response signals between a tester and the
// pattern BIST harness; clock and reset stay outside as plain ports.
interface pattern_bist_harness_if #(
   parameter int IN_W  = 11,
   parameter int OUT_W = 9,
   parameter int CNT_W = 16
);
   logic             start;
   logic [CNT_W-1:0] pattern_count;
   logic [OUT_W-1:0] golden_sig;
   logic [IN_W-1:0]  dut_in;
   logic [OUT_W-1:0] dut_resp;
   logic             busy;
   logic             done;
   logic             pass;
   logic [OUT_W-1:0] signature;

   modport master (
      output start, pattern_count, golden_sig, dut_resp,
      input  dut_in, busy, done, pass, signature
   );

   modport slave (
      input  start, pattern_count, golden_sig, dut_resp,
      output dut_in, busy, done, pass, signature
   );
endinterface

// File: rtl/pattern_bist_harness.sv
// LFSR-driven stimulus and MISR response compaction for a merged pattern
// block, with golden-signature comparison at the end of each run.
module pattern_bist_harness #(
   parameter int              IN_W      = 11,
   parameter int              OUT_W     = 9,
   parameter int              CNT_W     = 16,
   parameter int              FLUSH     = 4,
   parameter logic [IN_W-1:0] LFSR_SEED = 11'h001
) (
   input logic                    blif_clk_net,
   input logic                    blif_reset_net,
   pattern_bist_harness_if.slave  bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SEED  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [CNT_W:0] FLUSH_C = (CNT_W+1)'(FLUSH);

   logic [2:0]       state_q;
   logic [CNT_W-1:0] n_q;
   logic [CNT_W:0]   c_q;
   logic [IN_W-1:0]  lfsr_q;
   logic [IN_W-1:0]  dut_in_q;
   logic [OUT_W-1:0] misr_q;
   logic             pass_q;

   logic [CNT_W:0]   c_next;
   logic [CNT_W:0]   n_ext;
   logic [CNT_W:0]   drain_end;
   logic [IN_W-1:0]  lfsr_step;
   logic [OUT_W-1:0] misr_step;
   logic [OUT_W-1:0] misr_next;
   logic             capture;
   logic             start_ok;

   always_comb begin
      c_next    = c_q + 1'b1;
      n_ext     = {1'b0, n_q};
      drain_end = n_ext + FLUSH_C;
      lfsr_step = {lfsr_q[IN_W-2:0], lfsr_q[10] ^ lfsr_q[8]};
      misr_step = {misr_q[OUT_W-2:0], misr_q[OUT_W-1] ^ misr_q[4]} ^ bus.dut_resp;
      // Responses lag stimulus by FLUSH cycles, so capture starts at c=FLUSH
      // and ends at N+FLUSH-1: exactly N captures for any N.
      capture   = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (c_q >= FLUSH_C);
      misr_next = capture ? misr_step : misr_q;
      start_ok  = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
   end

   always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
      if (blif_reset_net) begin
         state_q  <= S_IDLE;
         n_q      <= '0;
         c_q      <= '0;
         lfsr_q   <= LFSR_SEED;
         dut_in_q <= '0;
         misr_q   <= '0;
         pass_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_ok) begin
                  state_q <= S_SEED;
                  n_q     <= bus.pattern_count;
                  pass_q  <= 1'b0;
                  misr_q  <= '0;
               end
            end
            S_SEED: begin
               lfsr_q <= LFSR_SEED;
               misr_q <= '0;
               c_q    <= '0;
               if (n_q != '0) begin
                  state_q  <= S_RUN;
                  dut_in_q <= LFSR_SEED;
               end else begin
                  state_q  <= S_DONE;
                  dut_in_q <= '0;
                  pass_q   <= (bus.golden_sig == '0);
               end
            end
            S_RUN: begin
               c_q    <= c_next;
               misr_q <= misr_next;
               lfsr_q <= lfsr_step;
               if (c_next == n_ext) begin
                  state_q  <= S_DRAIN;
                  dut_in_q <= '0;
               end else begin
                  dut_in_q <= lfsr_step;
               end
            end
            S_DRAIN: begin
               c_q    <= c_next;
               misr_q <= misr_next;
               if (c_next == drain_end) begin
                  state_q <= S_DONE;
                  pass_q  <= (misr_next == bus.golden_sig);
               end
            end
            default: begin
               state_q  <= S_IDLE;
               dut_in_q <= '0;
            end
         endcase
      end
   end

   assign bus.dut_in    = dut_in_q;
   assign bus.busy      = (state_q == S_SEED) || (state_q == S_RUN) || (state_q == S_DRAIN);
   assign bus.done      = (state_q == S_DONE);
   assign bus.pass      = pass_q;
   assign bus.signature = misr_q;

endmodule

// File: tb/tb_pattern_bist_harness.sv
// Scoreboard bench for pattern_bist_harness: stimulus pushes per-cycle and
// end-of-run expectations, a negedge monitor pops and compares them.
module tb_pattern_bist_harness;
   localparam int IN_W  = 11;
   localparam int OUT_W = 9;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [IN_W-1:0]  vec;
      logic [OUT_W-1:0] sig;
   } cyc_exp_t;

   typedef struct packed {
      logic [OUT_W-1:0] sig;
      logic             pass;
      int unsigned      lat;
   } res_exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pattern_bist_harness_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bif ();

   pattern_bist_harness #(
      .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .FLUSH(4), .LFSR_SEED(11'h001)
   ) dut (
      .blif_clk_net(clk),
      .blif_reset_net(rst),
      .bus(bif)
   );

   cyc_exp_t    vq[$];
   res_exp_t    rq[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   logic [IN_W-1:0]  vec_tbl  [10] = '{11'h001, 11'h002, 11'h004, 11'h008, 11'h010,
                                       11'h020, 11'h040, 11'h080, 11'h100, 11'h201};
   // MISR contents after k captures of a constant 0x001 response
   logic [OUT_W-1:0] sig1_tbl [10] = '{9'h001, 9'h003, 9'h007, 9'h00F, 9'h01F,
                                       9'h03E, 9'h07C, 9'h0F8, 9'h1F0, 9'h1E1};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [OUT_W-1:0] sig_after(input int caps, input logic r);
      if (caps == 0 || !r) return '0;
      return sig1_tbl[caps-1];
   endfunction

   // Monitor: one expectation per busy cycle, one per rising done.
   initial begin
      logic        busy_p = 1'b0;
      logic        done_p = 1'b0;
      int unsigned t_busy = 0;
      cyc_exp_t    e;
      res_exp_t    r;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_p = 1'b0;
            done_p = 1'b0;
         end else begin
            if (bif.busy) begin
               if (!busy_p) t_busy = cyc;
               if (vq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_busy: got busy=1 expected no busy cycle at t=%0t", $time);
               end else begin
                  e = vq.pop_front();
                  chk("dut_in", 32'(bif.dut_in), 32'(e.vec));
                  chk("sig_inflight", 32'(bif.signature), 32'(e.sig));
               end
            end else begin
               chk("idle_dut_in", 32'(bif.dut_in), 32'h0);
            end
            if (bif.done && !done_p) begin
               if (rq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done: got done=1 expected no completion at t=%0t", $time);
               end else begin
                  r = rq.pop_front();
                  chk("signature", 32'(bif.signature), 32'(r.sig));
                  chk("pass", 32'(bif.pass), 32'(r.pass));
                  chk("done_latency", cyc - t_busy, r.lat);
               end
            end
            busy_p = bif.busy;
            done_p = bif.done;
         end
      end
   end

   // Called one time unit after an edge; leaves control in the first DONE cycle.
   task automatic run(input int n, input logic r, input logic [OUT_W-1:0] golden,
                      input logic [OUT_W-1:0] esig, input logic epass, input int ign_at);
      bit got = 0;
      vq.push_back(cyc_exp_t'{vec: '0, sig: '0});
      if (n > 0) begin
         for (int c = 0; c < n + 4; c++) begin
            vq.push_back(cyc_exp_t'{vec: (c < n) ? vec_tbl[c] : '0,
                                    sig: sig_after((c < 4) ? 0 : c - 4, r)});
         end
      end
      rq.push_back(res_exp_t'{sig: esig, pass: epass, lat: (n == 0) ? 1 : n + 5});
      bif.pattern_count = CNT_W'(n);
      bif.golden_sig    = golden;
      bif.dut_resp      = r ? 9'h001 : 9'h000;
      bif.start         = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      chk("done_drop", 32'(bif.done), 32'h0);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         bif.start = (ign_at > 0) && (i + 1 == ign_at);
         if (bif.done) begin
            bif.start = 1'b0;
            got = 1;
            break;
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL done_timeout: got done=0 expected done within 100 cycles (N=%0d)", n);
      end
   endtask

   initial begin
      rst               = 1'b1;
      bif.start         = 1'b0;
      bif.pattern_count = '0;
      bif.golden_sig    = '0;
      bif.dut_resp      = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bif.busy), 32'h0);
      chk("rst_done", 32'(bif.done), 32'h0);
      chk("rst_pass", 32'(bif.pass), 32'h0);
      chk("rst_sig", 32'(bif.signature), 32'h0);
      chk("rst_dut_in", 32'(bif.dut_in), 32'h0);
      bif.start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_start_ignored", 32'(bif.busy), 32'h0);
      bif.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run(10, 1'b1, 9'h1E1, 9'h1E1, 1'b1, 0);
      run(5,  1'b0, 9'h000, 9'h000, 1'b1, 0);
      run(5,  1'b0, 9'h001, 9'h000, 1'b0, 0);
      run(2,  1'b1, 9'h003, 9'h003, 1'b1, 0);
      run(1,  1'b1, 9'h001, 9'h001, 1'b1, 0);
      run(0,  1'b1, 9'h000, 9'h000, 1'b1, 0);
      run(10, 1'b1, 9'h1E1, 9'h1E1, 1'b1, 3);
      run(6,  1'b1, 9'h03E, 9'h03E, 1'b1, 0);
      run(6,  1'b1, 9'h03E, 9'h03E, 1'b1, 0);

      // Abort a run at c=3 with an asynchronous reset pulse.
      vq.push_back(cyc_exp_t'{vec: '0, sig: '0});
      for (int c = 0; c < 4; c++) vq.push_back(cyc_exp_t'{vec: vec_tbl[c], sig: '0});
      bif.pattern_count = CNT_W'(10);
      bif.dut_resp      = 9'h001;
      bif.start         = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(bif.busy), 32'h0);
      chk("abort_dut_in", 32'(bif.dut_in), 32'h0);
      chk("abort_sig", 32'(bif.signature), 32'h0);
      chk("abort_done", 32'(bif.done), 32'h0);
      chk("abort_queue", 32'(vq.size()), 32'h0);
      vq.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run(10, 1'b1, 9'h1E1, 9'h1E1, 1'b1, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("cycle_queue_empty", 32'(vq.size()), 32'h0);
      chk("result_queue_empty", 32'(rq.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pattern_bist_harness.md
# pattern_bist_harness

Self-test harness for the merged pattern netlists: drives the 11-bit primary-input vector of a merged pattern block from an LFSR and compacts its 9-bit registered response into a MISR signature. At the end of a run it compares the signature against a golden value and reports pass/fail. It sits on the tester side of a merged pattern block, sharing that block's clock and reset.

## Interface

Parameters:
- IN_W, 11, width of the stimulus vector (pattern-block primary inputs, excluding clock and reset)
- OUT_W, 9, width of the response vector (pattern-block outputs)
- CNT_W, 16, width of pattern_count
- FLUSH, 4, pipeline depth of the pattern block; capture lags application by this many cycles
- LFSR_SEED, 11'h001, LFSR load value; nonzero

Ports:
- blif_clk_net  in  1  clock; all state updates on the rising edge
- blif_reset_net  in  1  asynchronous, active-high reset
- start  in  1  one-cycle run request; sampled only in IDLE and DONE
- pattern_count  in  CNT_W  number of vectors N; sampled on the accepted start
- golden_sig  in  OUT_W  expected signature; sampled in the cycle DONE is entered
- dut_in  out  IN_W  stimulus to the pattern block
- dut_resp  in  OUT_W  response from the pattern block
- busy  out  1  high in SEED, RUN and DRAIN
- done  out  1  high in DONE
- pass  out  1  comparison result; valid while done is high
- signature  out  OUT_W  MISR contents

## Operation

- States: IDLE, SEED, RUN, DRAIN, DONE.
- IDLE or DONE, start=1 -> SEED. Latch N, clear pass.
- SEED, one cycle:
  - load LFSR with LFSR_SEED
  - clear MISR to 0
  - clear cycle counter c to 0
  - go to RUN if N≠0, otherwise go to DONE
- RUN lasts N cycles, with c = 0..N-1:
  - dut_in = LFSR state
  - LFSR advances every RUN cycle
- DRAIN lasts FLUSH cycles, with c = N..N+FLUSH-1:
  - dut_in = 0
  - LFSR holds
- After the last DRAIN cycle -> DONE.
- Counter c is CNT_W+1 bits wide and increments every RUN and DRAIN cycle.
- Capture rule: the MISR updates in every RUN/DRAIN cycle with c ≥ FLUSH. The total number of captures is exactly N, for any N including N < FLUSH.
- LFSR is Fibonacci x^11+x^9+1: fb = q[10]^q[8]; q <= {q[9:0], fb}.
- MISR is x^9+x^5+1: m <= {m[7:0], m[8]^m[4]} ^ dut_resp.
- DONE:
  - pass = (signature == golden_sig), registered on entry to DONE
  - done, pass and signature hold until the next accepted start or reset
- start during busy is ignored.
- Outside RUN, dut_in = 0.

## Timing

- Reset values:
  - state IDLE
  - dut_in 0, busy 0, done 0, pass 0, signature 0
  - LFSR = LFSR_SEED, c = 0
- Reset asserted mid-run: all of the above take effect immediately (asynchronously). start is not re-sampled until reset is released.
- start accepted at edge k:
  - busy=1 from k+1 (SEED)
  - first vector on dut_in from k+2
  - done=1 from k+2+N+FLUSH; for N=0, from k+2
- dut_in is registered. Vector i is presented in RUN cycle c=i.
- The response captured at cycle c is attributed to vector c-FLUSH.
- signature reflects all N captures in the first DONE cycle.
- start in the DONE cycle is accepted: done drops at the next edge and SEED follows.

## Test plan

- N=10, FLUSH=4: dut_in sequence 0x001, 0x002, 0x004, 0x008, 0x010, 0x020, 0x040, 0x080, 0x100, 0x201, then 0. done rises exactly 16 cycles after the start edge.
- N=5, dut_resp tied to 0, golden_sig=0 -> signature=0, pass=1. Same run with golden_sig=0x001 -> pass=0.
- N=2, dut_resp tied to 0x001 -> signature=0x003. With N=1 -> signature=0x001, and the single capture lands in the first DRAIN cycle c=4.
- N=0 -> SEED then DONE. dut_in stays 0, signature=0, done two edges after start.
- Reset pulse mid-RUN (c=3): busy, dut_in and signature go to 0 without waiting for a clock edge. A new start runs normally and reproduces the 0x001 sequence.
- start pulsed during RUN is ignored. start in the DONE cycle restarts; a second identical run gives the same signature.
